uart_rx_fifo: RTL

Byte FIFO with hardware flow control between the UART receiver and the UART transmitter in the loopback/echo path. Accepts single-cycle byte strobes from the receiver and buffers them. Meters bytes out to the transmitter one at a time using its busy flag. Drives the CTS line so the host pauses before the buffer overflows.

---
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between UART receiver and transmitter with CTS flow control and paced tx handoff.
// Optional saturating dropped-byte counter: define UART_RX_FIFO_DROP_COUNT_EN.
//
// state        | meaning
// S_IDLE       | may hand the head byte to the transmitter when it is idle
// S_WAIT_BUSY  | start issued; waiting for tx_busy to rise (bounded by timeout)
// S_WAIT_DONE  | transmitter busy; waiting for it to finish
module uart_rx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int CTS_MARGIN   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  input  logic [7:0]            i_in_data,
  input  logic                  i_tx_busy,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  output logic                  o_uart_cts,
  output logic [DEPTH_LOG2:0]   o_fill,
  output logic                  o_overflow,
  output logic [7:0]            o_drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [DEPTH_LOG2:0] L_DEPTH    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] L_MARGIN   = (DEPTH_LOG2+1)'(CTS_MARGIN);
  localparam logic [TW-1:0]       L_TMO_LOAD = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_fill, w_fill_nxt, w_free_nxt;
  logic [TW-1:0]         r_timer, w_timer_nxt;
  logic                  r_tx_start, r_uart_cts, r_overflow;
  logic [7:0]            r_tx_data;
  logic                  w_push, w_drop, w_pop;

  // A full FIFO drops the byte even when a pop frees a slot in the same cycle.
  assign w_push = i_in_valid && (r_fill != L_DEPTH);
  assign w_drop = i_in_valid && (r_fill == L_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_fill != '0) && !i_tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT_BUSY;
          w_timer_nxt = L_TMO_LOAD;
        end
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy)
          w_state_nxt = S_WAIT_DONE;
        else if (r_timer == '0)
          w_state_nxt = S_IDLE;
        else
          w_timer_nxt = r_timer - TW'(1);
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop)
      w_fill_nxt = r_fill + (DEPTH_LOG2+1)'(1);
    else if (!w_push && w_pop)
      w_fill_nxt = r_fill - (DEPTH_LOG2+1)'(1);
  end

  assign w_free_nxt = L_DEPTH - w_fill_nxt;

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_in_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_uart_cts <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_fill     <= w_fill_nxt;
      r_tx_start <= w_pop;
      r_uart_cts <= (w_free_nxt > L_MARGIN);
      if (w_push)
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_drop_count <= 8'h00;
    else if (w_drop && (r_drop_count != 8'hFF))
      r_drop_count <= r_drop_count + 8'd1;
  end

  assign o_drop_count = r_drop_count;
`else
  assign o_drop_count = 8'h00;
`endif

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_uart_cts = r_uart_cts;
  assign o_fill     = r_fill;
  assign o_overflow = r_overflow;

endmodule
